// File: rtl/regfile_wb_arbiter_if.sv
// Bus bundle for the register-file write-port arbiter: pipeline WB, long-latency
// result handshake, decode hazard query and the register-file write port.
interface regfile_wb_arbiter_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
);
  logic              p_we;
  logic [ADDR_W-1:0] p_waddr;
  logic [DATA_W-1:0] p_wdata;
  logic              iss_valid;
  logic [ADDR_W-1:0] iss_addr;
  logic              l_valid;
  logic              l_ready;
  logic [ADDR_W-1:0] l_addr;
  logic [DATA_W-1:0] l_data;
  logic              q_re1;
  logic              q_re2;
  logic [ADDR_W-1:0] q_raddr1;
  logic [ADDR_W-1:0] q_raddr2;
  logic              q_we;
  logic [ADDR_W-1:0] q_waddr;
  logic              q_stall;
  logic              wb_hold;
  logic              err_waw;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;

  modport master (
    output p_we, p_waddr, p_wdata, iss_valid, iss_addr, l_valid, l_addr, l_data,
           q_re1, q_re2, q_raddr1, q_raddr2, q_we, q_waddr,
    input  l_ready, q_stall, wb_hold, err_waw, rf_we, rf_waddr, rf_wdata
  );

  modport slave (
    input  p_we, p_waddr, p_wdata, iss_valid, iss_addr, l_valid, l_addr, l_data,
           q_re1, q_re2, q_raddr1, q_raddr2, q_we, q_waddr,
    output l_ready, q_stall, wb_hold, err_waw, rf_we, rf_waddr, rf_wdata
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between WB (priority) and a buffered
// long-latency unit; tracks pending destinations to stall decode.
module regfile_wb_arbiter #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 3,
  parameter int NUM_REGS = 8,
  parameter int MAX_WAIT = 4
) (
  input logic               clk,
  input logic               rst,
  regfile_wb_arbiter_if.slave bus
);
  logic [1:0]          count;
  logic [ADDR_W-1:0]   q_addr [2];
  logic [DATA_W-1:0]   q_data [2];
  logic [NUM_REGS-1:0] busy, busy_nxt;
  logic [3:0]          wait_cnt;
  logic                ready, push, pop, full_wait;

  assign ready     = ~rst & (count < 2'd2);
  assign push      = bus.l_valid & ready;
  assign pop       = ~rst & ~bus.p_we & (count != 2'd0);
  assign full_wait = (wait_cnt == 4'(MAX_WAIT));

  // Issue is applied after the pop clear so a same-cycle set wins.
  always_comb begin
    busy_nxt = busy;
    if (pop)           busy_nxt[q_addr[0]]    = 1'b0;
    if (bus.iss_valid) busy_nxt[bus.iss_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      busy     <= '0;
      wait_cnt <= '0;
    end else begin
      busy <= busy_nxt;
      case ({push, pop})
        2'b10: begin
          q_addr[count[0]] <= bus.l_addr;
          q_data[count[0]] <= bus.l_data;
          count            <= count + 2'd1;
        end
        2'b01: begin
          q_addr[0] <= q_addr[1];
          q_data[0] <= q_data[1];
          count     <= count - 2'd1;
        end
        2'b11: begin
          // Only reachable with one entry: the new result becomes the head.
          q_addr[0] <= bus.l_addr;
          q_data[0] <= bus.l_data;
        end
        default: ;
      endcase
      if (pop || count == 2'd0)       wait_cnt <= '0;
      else if (bus.p_we && !full_wait) wait_cnt <= wait_cnt + 4'd1;
    end
  end

  always_comb begin
    bus.l_ready  = ready;
    bus.q_stall  = 1'b0;
    bus.wb_hold  = 1'b0;
    bus.err_waw  = 1'b0;
    bus.rf_we    = 1'b0;
    bus.rf_waddr = '0;
    bus.rf_wdata = '0;
    if (!rst) begin
      bus.q_stall = (bus.q_re1 & busy[bus.q_raddr1]) |
                    (bus.q_re2 & busy[bus.q_raddr2]) |
                    (bus.q_we  & busy[bus.q_waddr]);
      bus.wb_hold = full_wait;
      bus.err_waw = bus.iss_valid & busy[bus.iss_addr];
      if (bus.p_we) begin
        bus.rf_we    = 1'b1;
        bus.rf_waddr = bus.p_waddr;
        bus.rf_wdata = bus.p_wdata;
      end else if (count != 2'd0) begin
        bus.rf_we    = 1'b1;
        bus.rf_waddr = q_addr[0];
        bus.rf_wdata = q_data[0];
      end
    end
  end
endmodule
